stream_cipher_scheduler: RTL

Shares one stream-cipher XOR datapath between NUM_CH byte requesters.
- Each channel keeps its own 4-bit LFSR keystream state, so channels encrypt and decrypt independently.
- A round-robin arbiter admits one byte per cycle into a single-entry output register with valid/ready backpressure.
- The block sits between the message sources and the cipher consumers, and sequences keystream advance and reseeding.

---
 rtl/stream_cipher_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/stream_cipher_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/stream_cipher_pkg.sv
// Shared widths, FSM state type and keystream helpers for the stream cipher scheduler.
package stream_cipher_pkg;

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // x^4 + x^3 + 1 Fibonacci step, period 15
  function automatic logic [KEY_W-1:0] lfsr_next(input logic [KEY_W-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // The all-zero state locks the LFSR, so it is replaced by 1
  function automatic logic [KEY_W-1:0] seed_sanitize(input logic [KEY_W-1:0] s);
    return (s == '0) ? KEY_W'(1) : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping upward.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_CH);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_cipher_scheduler.sv
// Shares one LFSR-keystream XOR datapath between NUM_CH byte requesters,
// with round-robin admission into a single-entry valid/ready output register.
module stream_cipher_scheduler
  import stream_cipher_pkg::*;
#(
  parameter int unsigned      NUM_CH       = 2,
  parameter logic [KEY_W-1:0] DEFAULT_SEED = 4'b1001,
  parameter int unsigned      CH_W         = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [BYTE_W*NUM_CH-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        seed_load,
  input  logic [KEY_W-1:0]         seed_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [KEY_W-1:0]         out_key,
  output logic                     busy
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ptr_q;
  logic [KEY_W-1:0]  lfsr_q [NUM_CH];

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic              can_accept;
  logic              accept;
  logic [BYTE_W-1:0] sel_data;
  logic [KEY_W-1:0]  sel_key;

  // Channels being reseeded sit out arbitration this cycle
  assign eligible = req_valid & ~seed_load;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (CH_W)
  ) u_arb (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign can_accept = (state_q == EMPTY) || out_ready;
  assign accept     = grant_any && can_accept && !reset;
  assign req_ready  = accept ? grant : '0;
  assign out_valid  = (state_q == FULL);
  assign busy       = out_valid | (|req_valid);

  // One-hot mux of the granted channel's byte and pre-advance key
  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*BYTE_W +: BYTE_W];
        sel_key  = lfsr_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Result register only loads on acceptance, so it holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ch   <= '0;
      out_key  <= '0;
      ptr_q    <= '0;
    end else if (accept) begin
      out_data <= sel_data ^ {sel_key, sel_key};
      out_ch   <= grant_idx;
      out_key  <= sel_key;
      ptr_q    <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (reset)                    lfsr_q[i] <= DEFAULT_SEED;
      else if (seed_load[i])        lfsr_q[i] <= seed_sanitize(seed_value);
      else if (accept && grant[i])  lfsr_q[i] <= lfsr_next(lfsr_q[i]);
    end
  end

endmodule
